// File: rtl/uart_color_msg_tx.sv
// uart_color_msg_tx
// Takes one-hot colour requests over a valid/ready handshake, buffers one
// pending request and transmits a fixed 12-byte ASCII report over UART
// ("SI-SIM<D>-<L>-#\n"). The frame is 8N1 by default, with STOP_BITS stop bits.
// Optional even parity bit: define UART_COLOR_PARITY_EN to get 8E1/8E2 frames.
// tx, busy and msg_done are registered. tx therefore trails the FSM state by
// one cycle, which gives the two-cycle handshake-to-start-bit latency.
module uart_color_msg_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int CHANGE_ONLY  = 1
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       color_valid,
  output logic       color_ready,
  input  logic [2:0] color,
  output logic       tx,
  output logic       busy,
  output logic       msg_done,
  output logic       color_err
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [3:0]        LAST_BYTE = 4'd11;

  // The final cycle of the stop period is spent in NEXT. NEXT decides whether
  // to start the next byte or end the message, so there is no gap between bytes.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_COLOR_PARITY_EN
    PARITY,
`endif
    STOP,
    NEXT
  } state_t;

  state_t            state, state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [3:0]        byte_idx;
  logic [2:0]        cur_color, pend_color, last_color;
  logic              pend_full, pend_full_d;
  logic              accept, one_hot, store, drain;
  logic              baud_end;
  logic [7:0]        cur_byte;
  logic              tx_d, busy_d, done_d;

  // Report text: 'S' 'I' '-' 'S' 'I' 'M' D '-' L '-' '#' LF
  function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [2:0] col);
    logic [7:0] digit, letter;
    case (col)
      3'b100:  begin digit = 8'h31; letter = 8'h50; end  // '1' 'P'
      3'b010:  begin digit = 8'h32; letter = 8'h4E; end  // '2' 'N'
      default: begin digit = 8'h33; letter = 8'h57; end  // '3' 'W'
    endcase
    case (idx)
      4'd0, 4'd3:       msg_byte = 8'h53;  // 'S'
      4'd1, 4'd4:       msg_byte = 8'h49;  // 'I'
      4'd2, 4'd7, 4'd9: msg_byte = 8'h2D;  // '-'
      4'd5:             msg_byte = 8'h4D;  // 'M'
      4'd6:             msg_byte = digit;
      4'd8:             msg_byte = letter;
      4'd10:            msg_byte = 8'h23;  // '#'
      default:          msg_byte = 8'h0A;  // LF
    endcase
  endfunction

  assign accept      = color_valid && color_ready;
  assign one_hot     = (color == 3'b100) || (color == 3'b010) || (color == 3'b001);
  assign store       = accept && one_hot && !((CHANGE_ONLY != 0) && (color == last_color));
  assign drain       = (state == IDLE) && pend_full;
  assign pend_full_d = store ? 1'b1 : (drain ? 1'b0 : pend_full);
  assign baud_end    = (baud_cnt == BAUD_LAST);
  assign cur_byte    = msg_byte(byte_idx, cur_color);

  // Request handshake, one-entry pending buffer and last-colour filter
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      pend_full   <= 1'b0;
      color_ready <= 1'b1;
      pend_color  <= 3'b000;
      last_color  <= 3'b000;
      color_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values,
      // so the order of statements within the block has no effect.
      pend_full   <= pend_full_d;
      color_ready <= !pend_full_d;
      color_err   <= accept && !one_hot;
      if (store) begin
        pend_color <= color;
        last_color <= color;
      end
    end
  end

  // FSM state register with baud, bit and byte counters
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      byte_idx  <= 4'd0;
      cur_color <= 3'b000;
    end else begin
      state <= state_d;
      if ((state_d != state) || (state == IDLE) || baud_end) baud_cnt <= '0;
      else baud_cnt <= baud_cnt + 1'b1;
      if (state_d != state) bit_cnt <= 3'd0;
      else if (baud_end) bit_cnt <= bit_cnt + 3'd1;
      if (state == IDLE) byte_idx <= 4'd0;
      else if ((state == NEXT) && (state_d == START)) byte_idx <= byte_idx + 4'd1;
      if (drain) cur_color <= pend_color;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: assigning a default first keeps every path assigned, which avoids
    // inferring a latch.
    state_d = state;
    case (state)
      IDLE:  if (pend_full) state_d = START;
      START: if (baud_end) state_d = DATA;
`ifdef UART_COLOR_PARITY_EN
      DATA:   if (baud_end && (bit_cnt == 3'd7)) state_d = PARITY;
      PARITY: if (baud_end) state_d = STOP;
`else
      DATA:  if (baud_end && (bit_cnt == 3'd7)) state_d = STOP;
`endif
      STOP:  if ((bit_cnt == STOP_LAST) && (baud_cnt == BAUD_PRE)) state_d = NEXT;
      NEXT:  state_d = (byte_idx == LAST_BYTE) ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. Values are registered below.
  always_comb begin
    tx_d = 1'b1;
    case (state)
      START:  tx_d = 1'b0;
      DATA:   tx_d = cur_byte[bit_cnt];
`ifdef UART_COLOR_PARITY_EN
      PARITY: tx_d = ^cur_byte;
`endif
      default: tx_d = 1'b1;
    endcase
    // A waiting request keeps busy high through the single IDLE cycle between
    // back-to-back messages.
    busy_d = (state != IDLE) || pend_full;
    done_d = (state == NEXT) && (byte_idx == LAST_BYTE);
  end

  // Registered outputs
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      tx       <= tx_d;
      busy     <= busy_d;
      msg_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_color_msg_tx.sv
// Bench for uart_color_msg_tx. It uses two instances:
//   u_a: default parameters (434 clocks/bit, 1 stop bit, change-only filter)
//   u_b: 8 clocks/bit, 2 stop bits, every request sent
// Accepted requests push their expected report bytes into a per-instance queue.
// A UART monitor decodes each tx frame, checks every sample, and compares the
// decoded byte with the value at the head of the queue.
`timescale 1ns/1ps
module tb_uart_color_msg_tx;

`ifdef UART_COLOR_PARITY_EN
  localparam int P = 1;
  localparam int DUR_A = 57288;  // 12*11*434
  localparam int DUR_B = 1152;   // 12*12*8
`else
  localparam int P = 0;
  localparam int DUR_A = 52080;  // 12*10*434
  localparam int DUR_B = 1056;   // 12*11*8
`endif
  localparam int CPB_A = 434;
  localparam int CPB_B = 8;
  localparam int NB_A  = 1 + 8 + P + 1;
  localparam int NB_B  = 1 + 8 + P + 2;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       valid_a, valid_b, ready_a, ready_b;
  logic [2:0] color_a, color_b;
  logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [2:0] last_a, last_b;

  always #5 clk = ~clk;

  uart_color_msg_tx u_a (
    .clk_50(clk), .rst(rst_a), .color_valid(valid_a), .color_ready(ready_a),
    .color(color_a), .tx(tx_a), .busy(busy_a), .msg_done(done_a), .color_err(err_a)
  );

  uart_color_msg_tx #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(2), .CHANGE_ONLY(0)) u_b (
    .clk_50(clk), .rst(rst_b), .color_valid(valid_b), .color_ready(ready_b),
    .color(color_b), .tx(tx_b), .busy(busy_b), .msg_done(done_b), .color_err(err_b)
  );

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic tx_of(input int w);    return (w == 0) ? tx_a : tx_b;       endfunction
  function automatic logic busy_of(input int w);  return (w == 0) ? busy_a : busy_b;   endfunction
  function automatic logic done_of(input int w);  return (w == 0) ? done_a : done_b;   endfunction
  function automatic logic ready_of(input int w); return (w == 0) ? ready_a : ready_b; endfunction
  function automatic logic err_of(input int w);   return (w == 0) ? err_a : err_b;     endfunction
  function automatic logic rst_of(input int w);   return (w == 0) ? rst_a : rst_b;     endfunction

  task automatic push_msg(input int w, input logic [2:0] c);
    string s;
    case (c)
      3'b100:  s = "SI-SIM1-P-#\n";
      3'b010:  s = "SI-SIM2-N-#\n";
      default: s = "SI-SIM3-W-#\n";
    endcase
    for (int i = 0; i < s.len(); i++) begin
      if (w == 0) q_a.push_back(s[i]);
      else q_b.push_back(s[i]);
    end
  endtask

  // Drives one handshake and applies the bench's own acceptance model.
  // The task returns at the first falling edge after the handshake edge.
  task automatic send(input int w, input logic [2:0] c);
    logic exp_err;
    int   co;
    @(negedge clk);
    check((w == 0) ? "a_ready_before" : "b_ready_before", ready_of(w), 1);
    if (w == 0) begin valid_a = 1'b1; color_a = c; end
    else begin valid_b = 1'b1; color_b = c; end
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    co = (w == 0) ? 1 : 0;
    exp_err = !((c == 3'b100) || (c == 3'b010) || (c == 3'b001));
    if (!exp_err && !((co != 0) && (c == ((w == 0) ? last_a : last_b)))) begin
      push_msg(w, c);
      if (w == 0) last_a = c; else last_b = c;
    end
    check((w == 0) ? "a_color_err" : "b_color_err", err_of(w), exp_err);
  endtask

  // Counts falling edges until tx goes low, up to max.
  task automatic wait_low(input int w, input int max, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (tx_of(w) && (lat < max));
  endtask

  // Counts message cycles, starting at 1 on the current (start-bit) sample and
  // ending at the sample where msg_done is seen. Also counts samples with busy low.
  task automatic measure(input int w, input int max, output int dur, output int busy_bad);
    dur = 1;
    busy_bad = 0;
    forever begin
      if (!busy_of(w)) busy_bad++;
      if (done_of(w) || (dur >= max)) break;
      @(negedge clk);
      dur++;
    end
  endtask

  // Checks that tx, busy and color_err all stay low-activity for n cycles.
  task automatic idle_check(input int w, input int n, input string name);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!tx_of(w) || busy_of(w) || err_of(w)) bad++;
    end
    check(name, bad, 0);
  endtask

  // UART frame monitor. Samples every cycle of the frame and uses the
  // mid-bit samples to decode the data byte.
  task automatic monitor(input int w, input int cpb, input int nb);
    logic [7:0]  exp_byte, got;
    logic [11:0] exp_bits;
    int          bad;
    bit          abort;
    logic        s;
    forever begin
      @(negedge clk);
      if (!rst_of(w) && !tx_of(w)) begin
        check((w == 0) ? "a_frame_expected" : "b_frame_expected",
              ((w == 0) ? q_a.size() : q_b.size()) > 0 ? 1 : 0, 1);
        exp_byte = 8'h00;
        if ((w == 0) && (q_a.size() > 0)) exp_byte = q_a.pop_front();
        if ((w != 0) && (q_b.size() > 0)) exp_byte = q_b.pop_front();
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = exp_byte[i];
        if (P == 1) exp_bits[9] = ^exp_byte;
        bad = 0;
        got = 8'h00;
        abort = 1'b0;
        for (int b = 0; (b < nb) && !abort; b++) begin
          for (int c = 0; (c < cpb) && !abort; c++) begin
            if (!((b == 0) && (c == 0))) @(negedge clk);
            if (rst_of(w)) abort = 1'b1;
            else begin
              s = tx_of(w);
              if (s != exp_bits[b]) bad++;
              if ((c == cpb / 2) && (b >= 1) && (b <= 8)) got[b-1] = s;
            end
          end
        end
        if (!abort) begin
          check((w == 0) ? "a_byte" : "b_byte", got, exp_byte);
          check((w == 0) ? "a_frame_bits" : "b_frame_bits", bad, 0);
        end
      end
    end
  endtask

  initial monitor(0, CPB_A, NB_A);
  initial monitor(1, CPB_B, NB_B);

  initial begin
    #(800000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dur, bb, waited;
    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    color_a = 3'b000; color_b = 3'b000;
    last_a = 3'b000; last_b = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_tx", {tx_a, tx_b}, 2'b11);
    check("rst_busy", {busy_a, busy_b}, 2'b00);
    check("rst_done_err", {done_a, done_b, err_a, err_b}, 4'b0000);
    check("rst_ready", {ready_a, ready_b}, 2'b11);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // Default instance: red report, latency, duration, busy
    send(0, 3'b100);
    wait_low(0, 10, lat);
    check("a_latency", lat, 2);
    measure(0, DUR_A + 10, dur, bb);
    check("a_duration", dur, DUR_A);
    check("a_busy_during", bb, 0);
    @(negedge clk);
    check("a_busy_after", busy_a, 0);

    // Repeated colour is filtered out silently
    send(0, 3'b100);
    idle_check(0, 40, "a_repeat_dropped");

    // Invalid codes: one-cycle error pulse, no frame, last colour kept
    send(0, 3'b011);
    @(negedge clk);
    check("a_err_pulse_end", err_a, 0);
    send(0, 3'b000);
    idle_check(0, 20, "a_err_no_frame");
    send(0, 3'b100);
    idle_check(0, 40, "a_last_kept");

    // Fast instance: green, then blue accepted mid-message
    send(1, 3'b010);
    wait_low(1, 10, lat);
    check("b_latency", lat, 2);
    fork
      measure(1, DUR_B + 10, dur, bb);
      begin
        repeat (100) @(negedge clk);
        send(1, 3'b001);
        check("b_ready_low_after_accept", ready_b, 0);
      end
    join
    check("b_duration_1", dur, DUR_B);
    check("b_busy_1", bb, 0);
    check("b_ready_at_done", ready_b, 0);
    @(negedge clk);
    check("b_gap_tx_busy_ready", {tx_b, busy_b, ready_b}, 3'b111);
    @(negedge clk);
    check("b_second_start", tx_b, 0);
    measure(1, DUR_B + 10, dur, bb);
    check("b_duration_2", dur, DUR_B);
    check("b_busy_2", bb, 0);
    @(negedge clk);
    check("b_busy_after", busy_b, 0);

    // CHANGE_ONLY=0: the same colour twice gives two messages
    for (int k = 0; k < 2; k++) begin
      send(1, 3'b100);
      wait_low(1, 10, lat);
      check("b_repeat_latency", lat, 2);
      measure(1, DUR_B + 10, dur, bb);
      check("b_repeat_duration", dur, DUR_B);
    end

    // Invalid codes on the fast instance
    send(1, 3'b110);
    @(negedge clk);
    check("b_err_pulse_end", err_b, 0);
    send(1, 3'b000);
    idle_check(1, 30, "b_err_no_frame");

    // Reset in the middle of a message
    send(1, 3'b010);
    wait_low(1, 10, lat);
    repeat (200) @(negedge clk);
    @(posedge clk);
    #2 rst_b = 1'b1;
    #1;
    check("b_midrst_tx_busy", {tx_b, busy_b}, 2'b10);
    check("b_midrst_ready_done", {ready_b, done_b}, 2'b10);
    q_b.delete();
    last_b = 3'b000;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    send(1, 3'b001);
    wait_low(1, 10, lat);
    check("b_post_rst_latency", lat, 2);
    measure(1, DUR_B + 10, dur, bb);
    check("b_post_rst_duration", dur, DUR_B);

    // Scoreboard must be drained
    waited = 0;
    while (((q_a.size() + q_b.size()) != 0) && (waited < 50)) begin
      @(negedge clk);
      waited++;
    end
    check("queues_empty", q_a.size() + q_b.size(), 0);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
